// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that lets N_SRC word sources
// take turns writing bursts of at most BURST_MAX words into one FIFO.
module fifo_wr_arb #(
    parameter int N_SRC     = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SRC-1:0]    src_req,
    input  logic [N_SRC*DW-1:0] src_data,
    input  logic [N_SRC-1:0]    src_last,
    output logic [N_SRC-1:0]    src_ack,
    input  logic                wr_full,
    output logic                wr_req,
    output logic [DW-1:0]       wr_data,
    output logic [N_SRC-1:0]    grant,
    output logic [15:0]         wr_cnt
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t           r_state;
    logic [N_SRC-1:0] r_grant;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_ptr;
    logic [7:0]       r_burst;
    logic [15:0]      r_wr_cnt;

    logic [PW:0]      w_base;
    logic [N_SRC-1:0] w_rot;
    logic [PW:0]      w_off;
    logic [PW:0]      w_sum;
    logic [PW:0]      w_idx;
    logic [PW-1:0]    w_sel;
    logic [N_SRC-1:0] w_sel_oh;
    logic             w_any;

    logic             w_own_req;
    logic             w_own_last;
    logic [DW-1:0]    w_own_data;
    logic             w_wr_req;
    logic [7:0]       w_burst_nxt;
    logic             w_cap;
    logic             w_exit;

    // Next owner: first requester at or after ptr+1, wrapping.
    always_comb begin
        w_base = {1'b0, r_ptr} + (PW+1)'(1);
        w_rot  = N_SRC'({src_req, src_req} >> w_base);
        w_off  = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = (PW+1)'(j);
            end
        end
        w_sum = w_base + w_off;
        if (w_sum >= (PW+1)'(N_SRC)) begin
            w_idx = w_sum - (PW+1)'(N_SRC);
        end else begin
            w_idx = w_sum;
        end
        w_sel    = PW'(w_idx);
        w_sel_oh = {{(N_SRC-1){1'b0}}, 1'b1} << w_sel;
        w_any    = |src_req;
    end

    // Owner's request, last flag and data, muxed by the one-hot grant.
    always_comb begin
        w_own_req  = |(src_req & r_grant);
        w_own_last = |(src_last & r_grant);
        w_own_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant[i]) begin
                w_own_data = src_data[i*DW +: DW];
            end
        end
    end

    assign w_wr_req    = (r_state == S_XFER) & w_own_req
                       & ~wr_full & ~rst;
    assign w_burst_nxt = r_burst + 8'd1;
    assign w_cap       = (w_burst_nxt == 8'(BURST_MAX));
    assign w_exit      = (w_wr_req & (w_own_last | w_cap))
                       | (~w_own_req & ~wr_full);

    assign wr_req  = w_wr_req;
    assign src_ack = {N_SRC{w_wr_req}} & r_grant;
    assign wr_data = (rst | ~w_own_req) ? '0 : w_own_data;
    assign grant   = rst ? '0 : r_grant;
    assign wr_cnt  = rst ? '0 : r_wr_cnt;

    // Arbitration FSM: grant in IDLE, stream the burst in XFER.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= PW'(N_SRC - 1);
            r_burst <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_XFER;
                        r_owner <= w_sel;
                        r_grant <= w_sel_oh;
                        r_burst <= '0;
                    end
                end
                S_XFER: begin
                    if (w_wr_req) begin
                        r_burst <= w_burst_nxt;
                    end
                    if (w_exit) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_ptr   <= r_owner;
                    end
                end
            endcase
        end
    end

    // Running count of words written, wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_wr_req) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scenario tasks plus random traffic, every cycle
// compared against a packet-queue reference of the arbiter.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_req;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_last;
    logic [N-1:0]    src_ack;
    logic            wr_full;
    logic            wr_req;
    logic [DW-1:0]   wr_data;
    logic [N-1:0]    grant;
    logic [15:0]     wr_cnt;

    always #5 clk = ~clk;

    fifo_wr_arb #(.N_SRC(N), .DW(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .src_req(src_req), .src_data(src_data),
        .src_last(src_last), .src_ack(src_ack),
        .wr_full(wr_full), .wr_req(wr_req),
        .wr_data(wr_data), .grant(grant), .wr_cnt(wr_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    logic [7:0] qd [N][$];
    bit         ql [N][$];
    bit         en [N];
    bit         t_rst;
    bit         t_full;

    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_burst = 0;
    int m_cnt   = 0;

    logic [N-1:0]  e_grant;
    logic [N-1:0]  e_ack;
    logic          e_wreq;
    logic [DW-1:0] e_data;
    logic [15:0]   e_cnt;

    task automatic push_pkt(input int s, input int len, input bit has_last);
        for (int k = 0; k < len; k++) begin
            qd[s].push_back(8'($urandom));
            ql[s].push_back(has_last && (k == len - 1));
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
            en[i] = 1'b0;
        end
        t_full = 1'b0;
        t_rst  = 1'b0;
    endtask

    // drive one cycle of stimulus and advance the reference model
    task automatic cyc();
        int  g;
        int  idx;
        bit  r;
        bit  lst;
        @(negedge clk);
        rst     = t_rst;
        wr_full = t_full;
        for (int i = 0; i < N; i++) begin
            src_req[i] = en[i] && (qd[i].size() > 0);
            if (src_req[i]) begin
                src_data[i*DW +: DW] = qd[i][0];
                src_last[i] = ql[i][0];
            end else begin
                src_data[i*DW +: DW] = 8'($urandom);
                src_last[i] = 1'($urandom);
            end
        end
        #1;
        cyc_n++;
        e_grant = '0;
        e_wreq  = 1'b0;
        e_ack   = '0;
        e_data  = '0;
        e_cnt   = 16'(m_cnt);
        if (t_rst) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_burst = 0;
            m_cnt   = 0;
            e_cnt   = '0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && en[idx] && qd[idx].size() > 0) begin
                    m_owner = idx;
                    m_burst = 0;
                end
            end
        end else begin
            g = m_owner;
            r = en[g] && (qd[g].size() > 0);
            e_grant = N'(1) << g;
            e_wreq  = r && !t_full;
            if (r) e_data = qd[g][0];
            if (e_wreq) begin
                e_ack = e_grant;
                lst   = ql[g][0];
                void'(qd[g].pop_front());
                void'(ql[g].pop_front());
                m_burst++;
                m_cnt = (m_cnt + 1) % 65536;
                if (lst || m_burst == BM) begin
                    m_ptr   = g;
                    m_owner = -1;
                end
            end else if (!r && !t_full) begin
                m_ptr   = g;
                m_owner = -1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        t_rst = 1'b1;
        repeat (n) cyc();
        t_rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_all();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            push_pkt(i, 3, 1'b1);
        end
        t_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (grant !== '0 || wr_req !== 1'b0 ||
                src_ack !== '0 || wr_cnt !== '0) begin
                errors++;
                $display("FAIL reset c=%0d got g=%b w=%b a=%b cnt=%0d want all 0",
                         c, grant, wr_req, src_ack, wr_cnt);
            end
        end
        clear_all();
        cyc();
        checks++;
        if (grant !== '0 || wr_req !== 1'b0 || wr_cnt !== '0) begin
            errors++;
            $display("FAIL post_reset got g=%b w=%b cnt=%0d want 0 0 0",
                     grant, wr_req, wr_cnt);
        end
    endtask

    task automatic test_single();
        int nw = 0;
        clear_all();
        do_reset(1);
        push_pkt(0, 4, 1'b1);
        en[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL single cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
            if (wr_req) nw++;
            if (c == 0) begin
                checks++;
                if (grant !== 4'b0000) begin
                    errors++;
                    $display("FAIL single_arb_cycle got g=%b want 0000", grant);
                end
            end
            if (c == 1) begin
                checks++;
                if (grant !== 4'b0001 || wr_req !== 1'b1) begin
                    errors++;
                    $display("FAIL single_first_write got g=%b w=%b want 0001 1",
                             grant, wr_req);
                end
            end
        end
        checks++;
        if (nw != 4 || wr_cnt !== 16'd4 || grant !== '0) begin
            errors++;
            $display("FAIL single_total got writes=%0d cnt=%0d g=%b want 4 4 0000",
                     nw, wr_cnt, grant);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5];
        logic [N-1:0] gseq [5];
        int           wn [5];
        int           gap [5];
        int           bursts = 0;
        int           idle_run = 0;
        logic [N-1:0] prevg = '0;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int b = 0; b < 5; b++) begin
            gseq[b] = '0;
            wn[b]   = 0;
            gap[b]  = 0;
        end
        clear_all();
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 2, 1'b1);
            push_pkt(i, 2, 1'b1);
            en[i] = 1'b1;
        end
        for (int c = 0; c < 15; c++) begin
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL rr cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
            if (grant != '0 && prevg == '0 && bursts < 5) begin
                gseq[bursts] = grant;
                gap[bursts]  = idle_run;
                bursts++;
            end
            if (grant == '0) idle_run++;
            else idle_run = 0;
            if (wr_req && bursts > 0) wn[bursts-1]++;
            prevg = grant;
        end
        for (int b = 0; b < 5; b++) begin
            checks++;
            if (gseq[b] !== exp_g[b] || wn[b] != 2 || gap[b] != 1) begin
                errors++;
                $display("FAIL rr_burst%0d got g=%b writes=%0d gap=%0d want g=%b 2 1",
                         b, gseq[b], wn[b], gap[b], exp_g[b]);
            end
        end
    endtask

    task automatic test_burst_cap();
        int           n2 = 0;
        bit           left = 1'b0;
        logic [N-1:0] nxt = '0;
        clear_all();
        do_reset(1);
        push_pkt(2, 40, 1'b0);
        push_pkt(0, 3, 1'b1);
        en[2] = 1'b1;
        cyc();
        en[0] = 1'b1;
        for (int c = 0; c < 25; c++) begin
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL cap cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
            if (!left && src_ack == 4'b0100) n2++;
            if (n2 > 0 && grant == '0) left = 1'b1;
            if (left && nxt == '0 && grant != '0) nxt = grant;
        end
        checks++;
        if (n2 != 16 || nxt !== 4'b0001) begin
            errors++;
            $display("FAIL cap_result got src2_writes=%0d next=%b want 16 0001",
                     n2, nxt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] sent [$];
        logic [7:0] got [$];
        int         bad = 0;
        clear_all();
        do_reset(1);
        push_pkt(1, 8, 1'b1);
        sent = qd[1];
        en[1] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            t_full = (c >= 4 && c <= 6);
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL bp cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
            if (t_full) begin
                checks++;
                if (wr_req !== 1'b0 || src_ack !== '0 || grant !== 4'b0010) begin
                    errors++;
                    $display("FAIL bp_stall c=%0d got w=%b a=%b g=%b want 0 0000 0010",
                             c, wr_req, src_ack, grant);
                end
            end
            if (wr_req) got.push_back(wr_data);
        end
        t_full = 1'b0;
        if (got.size() == sent.size()) begin
            foreach (got[i]) if (got[i] !== sent[i]) bad++;
        end
        checks++;
        if (got.size() != 8 || bad != 0) begin
            errors++;
            $display("FAIL bp_stream got words=%0d wrong=%0d want 8 0",
                     got.size(), bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]   sent [$];
        int           nw = 0;
        bit           did = 1'b0;
        logic [N-1:0] g_after = '0;
        logic [7:0]   d_after = '0;
        bit           have_d = 1'b0;
        clear_all();
        do_reset(1);
        push_pkt(1, 10, 1'b1);
        push_pkt(3, 3, 1'b1);
        sent = qd[1];
        en[1] = 1'b1;
        en[3] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            t_rst = (nw == 5) && !did;
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL rmid cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
            if (t_rst) begin
                did = 1'b1;
                checks++;
                if (grant !== '0 || wr_req !== 1'b0 || src_ack !== '0 ||
                    wr_data !== '0 || wr_cnt !== '0) begin
                    errors++;
                    $display("FAIL rmid_outputs got g=%b w=%b a=%b d=%h c=%0d want zeros",
                             grant, wr_req, src_ack, wr_data, wr_cnt);
                end
            end else begin
                if (did && g_after == '0 && grant != '0) g_after = grant;
                if (did && wr_req && !have_d) begin
                    d_after = wr_data;
                    have_d  = 1'b1;
                end
                if (wr_req) nw++;
            end
        end
        t_rst = 1'b0;
        checks++;
        if (!did || g_after !== 4'b0010 || !have_d || d_after !== sent[5]) begin
            errors++;
            $display("FAIL rmid_rearb got reset=%0d g=%b d=%h want 1 0010 %h",
                     did, g_after, d_after, sent[5]);
        end
        checks++;
        if (wr_cnt !== 16'd8) begin
            errors++;
            $display("FAIL rmid_count got cnt=%0d want 8", wr_cnt);
        end
    endtask

    task automatic test_abandon();
        clear_all();
        do_reset(1);
        push_pkt(0, 6, 1'b1);
        push_pkt(2, 2, 1'b1);
        en[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            en[0] = (c < 3);
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL abandon cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
            if (c == 3) begin
                checks++;
                if (grant !== 4'b0001 || wr_req !== 1'b0 || wr_data !== '0) begin
                    errors++;
                    $display("FAIL abandon_drop got g=%b w=%b d=%h want 0001 0 00",
                             grant, wr_req, wr_data);
                end
            end
            if (c == 4) begin
                checks++;
                if (grant !== 4'b0000) begin
                    errors++;
                    $display("FAIL abandon_idle got g=%b want 0000", grant);
                end
            end
            if (c == 5) begin
                checks++;
                if (grant !== 4'b0100 || wr_req !== 1'b1) begin
                    errors++;
                    $display("FAIL abandon_next got g=%b w=%b want 0100 1",
                             grant, wr_req);
                end
            end
        end
    endtask

    task automatic test_cnt_wrap();
        int nw = 0;
        clear_all();
        do_reset(1);
        en[0] = 1'b1;
        for (int c = 0; c < 75000 && nw < 65540; c++) begin
            if (qd[0].size() < 4) push_pkt(0, 16, 1'b1);
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL wrap cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
            if (e_wreq) nw++;
        end
        en[0] = 1'b0;
        cyc();
        checks++;
        if (nw != 65540 || wr_cnt !== 16'd4) begin
            errors++;
            $display("FAIL wrap_final got writes=%0d cnt=%0d want 65540 4",
                     nw, wr_cnt);
        end
    endtask

    task automatic test_random();
        clear_all();
        do_reset(1);
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < N; s++) begin
                if (qd[s].size() == 0 && $urandom_range(2) == 0)
                    push_pkt(s, 1 + $urandom_range(19), 1'b1);
                en[s] = ($urandom_range(7) != 0);
            end
            t_full = ($urandom_range(3) == 0);
            t_rst  = ($urandom_range(149) == 0);
            cyc();
            checks++;
            if ({grant, wr_req, src_ack, wr_data, wr_cnt} !==
                {e_grant, e_wreq, e_ack, e_data, e_cnt}) begin
                errors++;
                $display("FAIL rand cyc=%0d got g=%b w=%b a=%b d=%h c=%0d want g=%b w=%b a=%b d=%h c=%0d",
                         cyc_n, grant, wr_req, src_ack, wr_data, wr_cnt,
                         e_grant, e_wreq, e_ack, e_data, e_cnt);
            end
        end
        t_rst  = 1'b0;
        t_full = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        wr_full  = 1'b0;
        src_req  = '0;
        src_data = '0;
        src_last = '0;
        clear_all();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_reset_mid();
        test_abandon();
        test_random();
        test_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Parameters
REQ-001 The block SHALL have parameter N_SRC, default 4, meaning number of write requesters (2..8).
REQ-002 The block SHALL have parameter DW, default 8, meaning data width.
REQ-003 The block SHALL have parameter BURST_MAX, default 16, meaning maximum words per grant (1..255).

Interface
REQ-004 The block SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port src_req, input, N_SRC, per-source word available.
REQ-007 The block SHALL have port src_data, input, N_SRC*DW, source i data at bits [i*DW +: DW].
REQ-008 The block SHALL have port src_last, input, N_SRC, current word ends source's packet.
REQ-009 The block SHALL have port src_ack, output, N_SRC, word of source i accepted this cycle.
REQ-010 The block SHALL have port wr_full, input, 1, FIFO full flag.
REQ-011 The block SHALL have port wr_req, output, 1, FIFO write strobe.
REQ-012 The block SHALL have port wr_data, output, DW, FIFO write data.
REQ-013 The block SHALL have port grant, output, N_SRC, one-hot owner, all-zero when idle.
REQ-014 The block SHALL have port wr_cnt, output, 16, total words written since reset.

Function
REQ-015 The block SHALL implement states IDLE and XFER, held in a register.
REQ-016 In IDLE, when src_req is nonzero, the block SHALL select the first set bit searching upward from (ptr+1) mod N_SRC, wrapping, and SHALL load grant and enter XFER next cycle.
REQ-017 In IDLE, grant, wr_req and src_ack SHALL be zero; the IDLE-to-XFER transition costs exactly one cycle.
REQ-018 In XFER with owner g, the block SHALL drive wr_req = src_req[g] & ~wr_full combinationally, wr_data = src_data[g], and src_ack[g] = wr_req; other src_ack bits SHALL be 0.
REQ-019 When owner g has src_req low, wr_req SHALL be 0 and wr_data SHALL be 0.
REQ-020 While wr_full is 1, the block SHALL assert no write and no ack, SHALL hold the burst counter, and SHALL remain in XFER.
REQ-021 An 8-bit burst counter SHALL clear on entry to XFER and increment on each accepted word.
REQ-022 XFER SHALL return to IDLE on the cycle after an accepted word with src_last[g]=1, or the cycle after the accepted word that brings the counter to BURST_MAX, or the cycle after src_req[g] is sampled low while wr_full is 0.
REQ-023 On every XFER exit, ptr SHALL be loaded with g, giving round-robin fairness.
REQ-024 src_last and the BURST_MAX limit coinciding on one word SHALL produce a single exit.
REQ-025 wr_cnt SHALL increment by 1 on each cycle with wr_req=1, wrapping from 0xFFFF to 0.
REQ-026 A source's req, data and last SHALL be sampled only in the cycle its ack would be issued; sources hold data until acked.

Reset
REQ-027 While rst=1, the block SHALL set state=IDLE, grant=0, burst counter=0, wr_cnt=0, and ptr=N_SRC-1 so source 0 has first priority.
REQ-028 During and after reset, wr_req and src_ack SHALL be 0 until the next grant.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no write in the reset cycle; the source SHALL be re-arbitrated normally afterwards.

Verification
REQ-030 Single source: src_req=0001 held, src_last on 4th word, wr_full=0 -> grant=0001 one cycle later, 4 consecutive wr_req with data matching source 0, return to IDLE, wr_cnt=4.
REQ-031 Round-robin: all four req held, packets of 2 words -> grant order 0001,0010,0100,1000,0001, each burst 2 writes separated by one idle cycle.
REQ-032 Burst cap: BURST_MAX=16, source 2 streams 40 words with no last, source 0 also requesting -> 16 writes from source 2, then grant moves to source 0.
REQ-033 Backpressure: wr_full=1 for 3 cycles mid-burst -> wr_req=0 and src_ack=0 for those cycles, no word lost or duplicated, burst count unchanged.
REQ-034 Reset mid-burst: rst=1 after 5 of 10 words -> outputs zero, wr_cnt=0, next grant goes to lowest requesting index from source 0.
REQ-035 Abandon: owner drops src_req with wr_full=0 -> IDLE next cycle, ptr=owner, other requester granted one cycle later.
